// File: rtl/mchan_cmd_pkg.sv
// Shared types and default widths for the DMA command splitter.
// The struct describes one emitted burst at the default widths.
package mchan_cmd_pkg;

   localparam int unsigned DEF_LEN_WIDTH    = 16;
   localparam int unsigned DEF_COUNT_WIDTH  = 16;
   localparam int unsigned DEF_STRIDE_WIDTH = 16;
   localparam int unsigned DEF_EXT_WIDTH    = 32;
   localparam int unsigned DEF_TCDM_WIDTH   = 16;
   localparam int unsigned DEF_SID_WIDTH    = 2;
   localparam int unsigned DEF_BURST_LENGTH = 64;
   localparam int unsigned BURST_OFF_WIDTH  = $clog2(DEF_BURST_LENGTH);

   typedef enum logic {
      StIdle = 1'b0,
      StRun  = 1'b1
   } state_e;

   typedef struct packed {
      logic [DEF_EXT_WIDTH-1:0]   ext_add;
      logic [DEF_TCDM_WIDTH-1:0]  tcdm_add;
      logic [BURST_OFF_WIDTH-1:0] len;
      logic [DEF_SID_WIDTH-1:0]   sid;
      logic                       row_last;
      logic                       last;
   } burst_cmd_t;

endpackage

// File: rtl/burst_boundary_calc.sv
// Size of the next burst: the smaller of the bytes left in the row and the
// bytes up to the next burst boundary; flags when that finishes the row.
module burst_boundary_calc #(
   parameter int unsigned REM_WIDTH = 17,
   parameter int unsigned OFF_WIDTH = 6
) (
   input  logic [REM_WIDTH-1:0] row_rem_i,
   input  logic [OFF_WIDTH-1:0] off_i,
   output logic [OFF_WIDTH:0]   bytes_o,
   output logic                 row_last_o
);

   localparam int unsigned CmpW = (REM_WIDTH > OFF_WIDTH + 1) ? REM_WIDTH : OFF_WIDTH + 1;

   logic [OFF_WIDTH:0] w_to_bnd;
   logic [CmpW-1:0]    w_rem_ext;
   logic [CmpW-1:0]    w_bnd_ext;

   always_comb begin
      w_to_bnd   = {1'b1, {OFF_WIDTH{1'b0}}} - {1'b0, off_i};
      w_rem_ext  = CmpW'(row_rem_i);
      w_bnd_ext  = CmpW'(w_to_bnd);
      row_last_o = (w_rem_ext <= w_bnd_ext);
      bytes_o    = row_last_o ? (OFF_WIDTH + 1)'(row_rem_i) : w_to_bnd;
   end

endmodule

// File: rtl/cmd_splitter_nd.sv
// Splits a linear or 2D DMA command into burst-aligned sub-commands.
// 2D support is built only when CMD_SPLIT_TWD_EN is defined.
module cmd_splitter_nd
   import mchan_cmd_pkg::*;
#(
   parameter int unsigned MCHAN_LEN_WIDTH    = DEF_LEN_WIDTH,
   parameter int unsigned TWD_COUNT_WIDTH    = DEF_COUNT_WIDTH,
   parameter int unsigned TWD_STRIDE_WIDTH   = DEF_STRIDE_WIDTH,
   parameter int unsigned EXT_ADD_WIDTH      = DEF_EXT_WIDTH,
   parameter int unsigned TCDM_ADD_WIDTH     = DEF_TCDM_WIDTH,
   parameter int unsigned TRANS_SID_WIDTH    = DEF_SID_WIDTH,
   parameter int unsigned MCHAN_BURST_LENGTH = DEF_BURST_LENGTH
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  cmd_valid_i,
   output logic                                  cmd_ready_o,
   input  logic [MCHAN_LEN_WIDTH-1:0]            cmd_len_i,
   input  logic                                  cmd_twd_i,
   input  logic [TWD_COUNT_WIDTH-1:0]            cmd_count_i,
   input  logic [TWD_STRIDE_WIDTH-1:0]           cmd_stride_i,
   input  logic [EXT_ADD_WIDTH-1:0]              cmd_ext_add_i,
   input  logic [TCDM_ADD_WIDTH-1:0]             cmd_tcdm_add_i,
   input  logic [TRANS_SID_WIDTH-1:0]            cmd_sid_i,
   output logic                                  burst_valid_o,
   input  logic                                  burst_ready_i,
   output logic [EXT_ADD_WIDTH-1:0]              burst_ext_add_o,
   output logic [TCDM_ADD_WIDTH-1:0]             burst_tcdm_add_o,
   output logic [$clog2(MCHAN_BURST_LENGTH)-1:0] burst_len_o,
   output logic [TRANS_SID_WIDTH-1:0]            burst_sid_o,
   output logic                                  burst_row_last_o,
   output logic                                  burst_last_o,
   output logic                                  busy_o
);

   localparam int unsigned OffW = $clog2(MCHAN_BURST_LENGTH);
   localparam int unsigned RemW =
      ((MCHAN_LEN_WIDTH > TWD_COUNT_WIDTH) ? MCHAN_LEN_WIDTH : TWD_COUNT_WIDTH) + 1;

   state_e                    r_state, w_state_next;
   logic [EXT_ADD_WIDTH-1:0]  r_ext_add;
   logic [TCDM_ADD_WIDTH-1:0] r_tcdm_add;
   logic [TRANS_SID_WIDTH-1:0] r_sid;
   logic [RemW-1:0]           r_row_rem;
   logic [RemW-1:0]           w_len_bytes;
   logic [OffW:0]             w_bytes;
   logic                      w_row_last;
   logic                      w_last;
   logic                      w_cmd_hs;
   logic                      w_burst_hs;
   logic [EXT_ADD_WIDTH-1:0]  w_ext_inc;

   assign w_len_bytes = RemW'(cmd_len_i) + RemW'(1);
   assign w_cmd_hs    = cmd_valid_i & (r_state == StIdle);
   assign w_burst_hs  = burst_ready_i & (r_state == StRun);
   assign w_ext_inc   = r_ext_add + EXT_ADD_WIDTH'(w_bytes);

   burst_boundary_calc #(
      .REM_WIDTH (RemW),
      .OFF_WIDTH (OffW)
   ) u_calc (
      .row_rem_i  (r_row_rem),
      .off_i      (r_ext_add[OffW-1:0]),
      .bytes_o    (w_bytes),
      .row_last_o (w_row_last)
   );

`ifdef CMD_SPLIT_TWD_EN
   logic [EXT_ADD_WIDTH-1:0] r_row_ext;
   logic [EXT_ADD_WIDTH-1:0] r_pitch;
   logic [RemW-1:0]          r_row_bytes;
   logic [RemW-1:0]          r_tot_rem;
   logic [RemW-1:0]          w_row_in;
   logic [RemW-1:0]          w_tot_next;
   logic [EXT_ADD_WIDTH-1:0] w_next_row;
   logic                     w_is_2d;

   assign w_row_in   = RemW'(cmd_count_i) + RemW'(1);
   // A row at least as long as the transfer degenerates to a single row.
   assign w_is_2d    = cmd_twd_i & (w_row_in < w_len_bytes);
   assign w_tot_next = r_tot_rem - RemW'(w_bytes);
   assign w_next_row = r_row_ext + r_pitch;
   assign w_last     = w_row_last & (r_tot_rem == RemW'(w_bytes));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_row_ext   <= '0;
         r_pitch     <= '0;
         r_row_bytes <= '0;
         r_tot_rem   <= '0;
      end else if (w_cmd_hs) begin
         r_row_ext   <= cmd_ext_add_i;
         r_pitch     <= EXT_ADD_WIDTH'(cmd_stride_i) + EXT_ADD_WIDTH'(1);
         r_row_bytes <= w_is_2d ? w_row_in : w_len_bytes;
         r_tot_rem   <= w_len_bytes;
      end else if (w_burst_hs) begin
         r_tot_rem <= w_tot_next;
         if (w_row_last) r_row_ext <= w_next_row;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ext_add <= '0;
         r_row_rem <= '0;
      end else if (w_cmd_hs) begin
         r_ext_add <= cmd_ext_add_i;
         r_row_rem <= w_is_2d ? w_row_in : w_len_bytes;
      end else if (w_burst_hs) begin
         if (w_row_last) begin
            r_ext_add <= w_next_row;
            r_row_rem <= (r_row_bytes < w_tot_next) ? r_row_bytes : w_tot_next;
         end else begin
            r_ext_add <= w_ext_inc;
            r_row_rem <= r_row_rem - RemW'(w_bytes);
         end
      end
   end
`else
   logic w_unused_2d;
   assign w_unused_2d = ^{cmd_twd_i, cmd_count_i, cmd_stride_i};
   assign w_last      = w_row_last;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ext_add <= '0;
         r_row_rem <= '0;
      end else if (w_cmd_hs) begin
         r_ext_add <= cmd_ext_add_i;
         r_row_rem <= w_len_bytes;
      end else if (w_burst_hs) begin
         r_ext_add <= w_ext_inc;
         r_row_rem <= r_row_rem - RemW'(w_bytes);
      end
   end
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_tcdm_add <= '0;
         r_sid      <= '0;
      end else if (w_cmd_hs) begin
         r_tcdm_add <= cmd_tcdm_add_i;
         r_sid      <= cmd_sid_i;
      end else if (w_burst_hs) begin
         r_tcdm_add <= r_tcdm_add + TCDM_ADD_WIDTH'(w_bytes);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= StIdle;
      else         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: if (cmd_valid_i) w_state_next = StRun;
         StRun:  if (burst_ready_i && w_last) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // Burst fields are forced to zero outside RUN so idle outputs match reset.
   always_comb begin
      cmd_ready_o      = (r_state == StIdle);
      busy_o           = (r_state == StRun);
      burst_valid_o    = (r_state == StRun);
      burst_ext_add_o  = '0;
      burst_tcdm_add_o = '0;
      burst_len_o      = '0;
      burst_sid_o      = '0;
      burst_row_last_o = 1'b0;
      burst_last_o     = 1'b0;
      if (r_state == StRun) begin
         burst_ext_add_o  = r_ext_add;
         burst_tcdm_add_o = r_tcdm_add;
         burst_len_o      = OffW'(w_bytes - (OffW + 1)'(1));
         burst_sid_o      = r_sid;
         burst_row_last_o = w_row_last;
         burst_last_o     = w_last;
      end
   end

endmodule
